// File: rtl/bcd_counter_n.sv
// N-digit synchronous BCD up/down counter with validated parallel load, carry/borrow flag and display hold register.
// Define BCD_COUNTER_SAT_EN to saturate at the count bounds instead of wrapping.
module bcd_counter_n #(
  parameter int unsigned DIGITS = 6
) (
  input  logic                F_IN,
  input  logic                CLR,
  input  logic                ENA,
  input  logic                UP,
  input  logic                LOAD,
  input  logic [4*DIGITS-1:0] D,
  input  logic                LATCH,
  output logic [4*DIGITS-1:0] Q,
  output logic [4*DIGITS-1:0] Q_HOLD,
  output logic                CO,
  output logic                ERR
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] q_q, q_d;
  logic [W-1:0] hold_q, hold_d;
  logic         co_q, co_d;
  logic         err_q, err_d;

  logic [W-1:0] inc_c, dec_c;
  logic         all9_c, all0_c, d_ok_c;

  // Ripple the carry/borrow through the digits; all9/all0 end up as the carry/borrow out.
  always_comb begin
    inc_c  = q_q;
    dec_c  = q_q;
    all9_c = 1'b1;
    all0_c = 1'b1;
    d_ok_c = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (all9_c) begin
        if (q_q[4*i +: 4] == 4'd9) begin
          inc_c[4*i +: 4] = 4'd0;
        end else begin
          inc_c[4*i +: 4] = q_q[4*i +: 4] + 4'd1;
          all9_c          = 1'b0;
        end
      end
      if (all0_c) begin
        if (q_q[4*i +: 4] == 4'd0) begin
          dec_c[4*i +: 4] = 4'd9;
        end else begin
          dec_c[4*i +: 4] = q_q[4*i +: 4] - 4'd1;
          all0_c          = 1'b0;
        end
      end
      if (D[4*i +: 4] > 4'd9) begin
        d_ok_c = 1'b0;
      end
    end
  end

  // Next state; the hold register samples the pre-update count.
  always_comb begin
    q_d    = q_q;
    hold_d = hold_q;
    co_d   = 1'b0;
    err_d  = 1'b0;
    if (LATCH) begin
      hold_d = q_q;
    end
    if (LOAD) begin
      if (d_ok_c) begin
        q_d = D;
      end else begin
        err_d = 1'b1;
      end
    end else if (ENA) begin
      if (UP) begin
        co_d = all9_c;
`ifdef BCD_COUNTER_SAT_EN
        if (!all9_c) begin
          q_d = inc_c;
        end
`else
        q_d = inc_c;
`endif
      end else begin
        co_d = all0_c;
`ifdef BCD_COUNTER_SAT_EN
        if (!all0_c) begin
          q_d = dec_c;
        end
`else
        q_d = dec_c;
`endif
      end
    end
  end

  always_ff @(posedge F_IN) begin
    if (CLR) begin
      q_q    <= '0;
      hold_q <= '0;
      co_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      hold_q <= hold_d;
      co_q   <= co_d;
      err_q  <= err_d;
    end
  end

  assign Q      = q_q;
  assign Q_HOLD = hold_q;
  assign CO     = co_q;
  assign ERR    = err_q;

endmodule
